// File: rtl/game_ctl.sv
// Screen sequencer for the VGA shooting game: IDLE/WAIT/PLAY/SCORE, target spawn, hit scoring, round timer.
// Optional macro SCORE_AUTO_RETURN_EN: SCORE returns to IDLE on its own after SCORE_FRAMES ticks.
module game_ctl #(
    parameter int unsigned ROUND_FRAMES  = 1800,
    parameter int unsigned TARGET_FRAMES = 45,
    parameter int unsigned TARGET_SIZE   = 32
`ifdef SCORE_AUTO_RETURN_EN
    , parameter int unsigned SCORE_FRAMES = 300
`endif
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        play_clicked,
    input  logic        uart_start,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [9:0]  hor_ran,
    input  logic [9:0]  ver_ran,
    output logic [1:0]  state,
    output logic [10:0] target_x,
    output logic [10:0] target_y,
    output logic        target_valid,
    output logic [15:0] my_score,
    output logic [10:0] frames_left,
    output logic        round_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_PLAY  = 2'b10,
        S_SCORE = 2'b11
    } state_e;

    localparam int unsigned AGE_W     = $clog2(TARGET_FRAMES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TARGET_FRAMES - 1);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [11:0] SIZE12    = 12'(TARGET_SIZE);
    localparam logic [9:0]  SIZE10    = 10'(TARGET_SIZE);
    localparam logic [9:0]  X_LIM     = 10'(1024 - TARGET_SIZE);
    localparam logic [9:0]  Y_LIM     = 10'(768 - TARGET_SIZE);
    localparam logic [10:0] ROUND_LEN = 11'(ROUND_FRAMES);
`ifdef SCORE_AUTO_RETURN_EN
    localparam int unsigned SC_W = $clog2(SCORE_FRAMES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCORE_FRAMES - 1);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
`endif

    state_e             state_q, state_d;
    logic               vsync_q, ml_q;
    logic [10:0]        target_x_q, target_x_d;
    logic [10:0]        target_y_q, target_y_d;
    logic               valid_q, valid_d;
    logic [15:0]        score_q, score_d;
    logic [10:0]        frames_q, frames_d;
    logic               round_done_q, round_done_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               pend_q, pend_d;
`ifdef SCORE_AUTO_RETURN_EN
    logic [SC_W-1:0]    sc_cnt_q, sc_cnt_d;
`endif

    logic tick_c, click_c, in_x_c, in_y_c, hit_c;

    // BCD increment of a 4-digit value; caller handles saturation
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick_c  = vsync & ~vsync_q;
    assign click_c = mouse_left & ~ml_q;
    assign in_x_c  = (mouse_xpos >= 12'(target_x_q)) && (mouse_xpos < 12'(target_x_q) + SIZE12);
    assign in_y_c  = (mouse_ypos >= 12'(target_y_q)) && (mouse_ypos < 12'(target_y_q) + SIZE12);
    assign hit_c   = click_c & valid_q & in_x_c & in_y_c;

    always_comb begin
        state_d      = state_q;
        target_x_d   = target_x_q;
        target_y_d   = target_y_q;
        valid_d      = valid_q;
        score_d      = score_q;
        frames_d     = frames_q;
        round_done_d = 1'b0;
        age_d        = age_q;
        pend_d       = pend_q;
`ifdef SCORE_AUTO_RETURN_EN
        sc_cnt_d     = sc_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (play_clicked) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (uart_start) begin
                    state_d  = S_PLAY;
                    frames_d = ROUND_LEN;
                    score_d  = 16'h0000;
                    valid_d  = 1'b0;
                    pend_d   = 1'b1;
                    age_d    = '0;
                end
            end
            S_PLAY: begin
                if (hit_c) begin
                    if (score_q != 16'h9999) score_d = bcd_inc(score_q);
                    valid_d = 1'b0;
                    pend_d  = 1'b1;
                end
                if (tick_c) begin
                    if (frames_q == 11'd1) begin
                        state_d      = S_SCORE;
                        frames_d     = 11'd0;
                        round_done_d = 1'b1;
                        valid_d      = 1'b0;
                        pend_d       = 1'b0;
`ifdef SCORE_AUTO_RETURN_EN
                        sc_cnt_d     = '0;
`endif
                    end else begin
                        if (frames_q != 11'd0) frames_d = frames_q - 11'd1;
                        // a hit on this cycle already owns valid/pend
                        if (!hit_c) begin
                            if (pend_q) begin
                                target_x_d = (hor_ran >= X_LIM) ? 11'(hor_ran - SIZE10) : 11'(hor_ran);
                                target_y_d = (ver_ran >= Y_LIM) ? 11'(ver_ran - 10'd256) : 11'(ver_ran);
                                valid_d    = 1'b1;
                                pend_d     = 1'b0;
                                age_d      = '0;
                            end else if (valid_q) begin
                                if (age_q == AGE_MAX) begin
                                    valid_d = 1'b0;
                                    pend_d  = 1'b1;
                                end else begin
                                    age_d = age_q + AGE_ONE;
                                end
                            end
                        end
                    end
                end
            end
            S_SCORE: begin
`ifdef SCORE_AUTO_RETURN_EN
                if (play_clicked) begin
                    state_d = S_IDLE;
                end else if (tick_c) begin
                    if (sc_cnt_q == SC_MAX) state_d = S_IDLE;
                    else                    sc_cnt_d = sc_cnt_q + SC_ONE;
                end
`else
                if (play_clicked) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            ml_q         <= 1'b0;
            target_x_q   <= 11'd0;
            target_y_q   <= 11'd0;
            valid_q      <= 1'b0;
            score_q      <= 16'h0000;
            frames_q     <= 11'd0;
            round_done_q <= 1'b0;
            age_q        <= '0;
            pend_q       <= 1'b0;
`ifdef SCORE_AUTO_RETURN_EN
            sc_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            ml_q         <= mouse_left;
            target_x_q   <= target_x_d;
            target_y_q   <= target_y_d;
            valid_q      <= valid_d;
            score_q      <= score_d;
            frames_q     <= frames_d;
            round_done_q <= round_done_d;
            age_q        <= age_d;
            pend_q       <= pend_d;
`ifdef SCORE_AUTO_RETURN_EN
            sc_cnt_q     <= sc_cnt_d;
`endif
        end
    end

    assign state        = state_q;
    assign target_x     = target_x_q;
    assign target_y     = target_y_q;
    assign target_valid = valid_q;
    assign my_score     = score_q;
    assign frames_left  = frames_q;
    assign round_done   = round_done_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: reset, state flow, spawn clamping, hits, target aging, final-tick hit.
module tb_game_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        play_clicked = 1'b0;
    logic        uart_start = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic [9:0]  hor_ran = 10'd0;
    logic [9:0]  ver_ran = 10'd0;
    logic [1:0]  state;
    logic [10:0] target_x, target_y, frames_left;
    logic        target_valid, round_done;
    logic [15:0] my_score;

    int n_chk = 0;
    int n_fail = 0;

    // expectation model for the round: timer, target life and hit count
    int exp_frames = 0;
    int hits = 0;
    bit m_valid = 0, m_pend = 0;
    int m_age = 0, m_tx = 0, m_ty = 0;

    game_ctl dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .play_clicked(play_clicked),
        .uart_start(uart_start), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .hor_ran(hor_ran), .ver_ran(ver_ran), .state(state),
        .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
        .my_score(my_score), .frames_left(frames_left), .round_done(round_done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        int v;
        v = (n > 9999) ? 9999 : n;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_x(input int h);
        return (h >= 992) ? h - 32 : h;
    endfunction

    function automatic int clamp_y(input int v);
        return (v >= 736) ? v - 256 : v;
    endfunction

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_play();
        play_clicked = 1'b1;
        cyc();
        play_clicked = 1'b0;
    endtask

    task automatic do_tick();
        vsync = 1'b1;
        cyc();
        vsync = 1'b0;
        cyc();
        if (exp_frames > 1) begin
            exp_frames--;
            if (m_pend) begin
                m_pend = 0; m_valid = 1; m_age = 0;
                m_tx = clamp_x(int'(hor_ran)); m_ty = clamp_y(int'(ver_ran));
            end else if (m_valid) begin
                if (m_age == 44) begin m_valid = 0; m_pend = 1; end
                else m_age++;
            end
        end
    endtask

    task automatic do_click(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        cyc();
        mouse_left = 1'b0;
        cyc();
        if (m_valid && x >= m_tx && x < m_tx + 32 && y >= m_ty && y < m_ty + 32) begin
            hits++; m_valid = 0; m_pend = 1;
        end
    endtask

    initial begin
        // reset with inputs toggling
        for (int i = 0; i < 3; i++) begin
            vsync = ~vsync; mouse_left = ~mouse_left; play_clicked = ~play_clicked;
            uart_start = 1'b1; hor_ran = 10'(i * 77); mouse_xpos = 12'(i * 5);
            cyc();
        end
        check("rst_state", 32'(state), 32'd0);
        check("rst_tx", 32'(target_x), 32'd0);
        check("rst_ty", 32'(target_y), 32'd0);
        check("rst_valid", 32'(target_valid), 32'd0);
        check("rst_score", 32'(my_score), 32'd0);
        check("rst_frames", 32'(frames_left), 32'd0);
        check("rst_done", 32'(round_done), 32'd0);
        vsync = 0; mouse_left = 0; play_clicked = 0; uart_start = 0; rst = 0;
        cyc();

        uart_start = 1; cyc(); uart_start = 0;
        check("idle_ignores_uart", 32'(state), 32'd0);
        pulse_play();
        check("idle_to_wait", 32'(state), 32'd1);
        pulse_play();
        check("wait_ignores_play", 32'(state), 32'd1);

        hor_ran = 10'd100; ver_ran = 10'd200;
        uart_start = 1; cyc(); uart_start = 0;
        exp_frames = 1800; m_pend = 1; m_valid = 0; hits = 0;
        check("wait_to_play", 32'(state), 32'd2);
        check("play_frames", 32'(frames_left), 32'd1800);
        check("play_score0", 32'(my_score), 32'd0);
        check("play_valid0", 32'(target_valid), 32'd0);

        do_tick();
        check("spawn_valid", 32'(target_valid), 32'd1);
        check("spawn_x", 32'(target_x), 32'd100);
        check("spawn_y", 32'(target_y), 32'd200);
        check("tick_frames", 32'(frames_left), 32'd1799);

        do_click(131, 231);
        check("hit_corner_score", 32'(my_score), 32'h0001);
        check("hit_clears_valid", 32'(target_valid), 32'd0);
        do_click(131, 231);
        check("click_no_target", 32'(my_score), 32'h0001);

        do_tick();
        check("respawn_valid", 32'(target_valid), 32'd1);
        do_click(132, 200);
        check("miss_x_edge", 32'(my_score), 32'h0001);
        do_click(131, 232);
        check("miss_y_edge", 32'(my_score), 32'h0001);
        do_click(99, 231);
        check("miss_x_low", 32'(my_score), 32'h0001);
        check("miss_keeps_valid", 32'(target_valid), 32'd1);

        hor_ran = 10'd1000; ver_ran = 10'd760;
        do_click(100, 200);
        check("hit_origin", 32'(my_score), 32'h0002);
        do_tick();
        check("clamp_x", 32'(target_x), 32'd968);
        check("clamp_y", 32'(target_y), 32'd504);

        for (int i = 0; i < 44; i++) do_tick();
        check("age_44_valid", 32'(target_valid), 32'd1);
        do_tick();
        check("age_expire", 32'(target_valid), 32'd0);
        hor_ran = 10'd500; ver_ran = 10'd300;
        do_tick();
        check("age_respawn", 32'(target_valid), 32'd1);
        check("age_respawn_x", 32'(target_x), 32'd500);

        for (int i = 0; i < 8; i++) begin
            do_click(510, 310);
            do_tick();
        end
        check("bcd_carry", 32'(my_score), 32'h0010);
        check("frames_mid", 32'(frames_left), 32'(exp_frames));

        // run the round down, keeping a live target for the final tick
        while (exp_frames > 2) do_tick();
        if (m_valid && m_age == 44) do_click(m_tx + 3, m_ty + 3);
        do_tick();
        check("pre_final_frames", 32'(frames_left), 32'd1);
        check("pre_final_valid", 32'(target_valid), 32'd1);
        check("pre_final_score", 32'(my_score), 32'(to_bcd(hits)));

        mouse_xpos = 12'(m_tx + 16); mouse_ypos = 12'(m_ty + 16);
        vsync = 1; mouse_left = 1;
        cyc();
        vsync = 0; mouse_left = 0;
        hits++; exp_frames = 0;
        check("final_hit_score", 32'(my_score), 32'(to_bcd(hits)));
        check("final_state", 32'(state), 32'd3);
        check("final_frames", 32'(frames_left), 32'd0);
        check("final_done", 32'(round_done), 32'd1);
        check("final_valid", 32'(target_valid), 32'd0);
        cyc();
        check("done_one_cycle", 32'(round_done), 32'd0);

        for (int i = 0; i < 299; i++) do_tick();
        check("score_dwell_299", 32'(state), 32'd3);
        do_tick();
`ifdef SCORE_AUTO_RETURN_EN
        check("score_auto_return", 32'(state), 32'd0);
`else
        check("score_stays", 32'(state), 32'd3);
`endif
        check("score_holds", 32'(my_score), 32'(to_bcd(hits)));
        check("frames_hold", 32'(frames_left), 32'd0);
`ifndef SCORE_AUTO_RETURN_EN
        pulse_play();
        check("score_to_idle", 32'(state), 32'd0);
`endif
        pulse_play();
        check("second_wait", 32'(state), 32'd1);
        uart_start = 1; cyc(); uart_start = 0;
        check("second_play", 32'(state), 32'd2);
        check("second_score0", 32'(my_score), 32'd0);
        check("second_frames", 32'(frames_left), 32'd1800);
        do_tick();
        do_tick();
        rst = 1; cyc(); rst = 0;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_frames", 32'(frames_left), 32'd0);
        check("midrst_valid", 32'(target_valid), 32'd0);
        check("midrst_tx", 32'(target_x), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
